// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding byte/half/word access to a word-wide data memory.
// Sub-word stores are read-modify-write; read waits are bounded by TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for i_req; captures the request
// READ    | strobing memory until ack or timeout
// WRITE   | one-cycle word write (full word or merged sub-word)
// RESP    | one-cycle o_done with result and fault flags
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_misaligned,
   output logic        o_bus_err,
   output logic        o_mem_stb,
   output logic        o_mem_wr_en,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   localparam logic [4:0] LP_CNT_LAST = 5'(TIMEOUT - 1);

   state_t      r_state, w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_word;
   logic [4:0]  r_cnt;
   logic        r_mis;
   logic        r_berr;

   logic        w_illegal;
   logic        w_misal;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign w_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_we && i_funct3[2]);
   assign w_misal   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               if (w_illegal || w_misal)
                  w_next = S_RESP;
               else if (i_we && (i_funct3[1:0] == 2'b10))
                  w_next = S_WRITE;
               else
                  w_next = S_READ;
            end
         end
         S_READ: begin
            if (i_mem_ack)
               w_next = r_we ? S_WRITE : S_RESP;
            else if (r_cnt == LP_CNT_LAST)
               w_next = S_RESP;
         end
         S_WRITE: w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_word   <= 32'h0;
         r_cnt    <= 5'd0;
         r_mis    <= 1'b0;
         r_berr   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_we     <= i_we;
                  r_funct3 <= i_funct3;
                  r_addr   <= i_addr;
                  r_wdata  <= i_wdata;
                  r_word   <= 32'h0;
                  r_cnt    <= 5'd0;
                  r_berr   <= w_illegal;
                  r_mis    <= !w_illegal && w_misal;
               end
            end
            S_READ: begin
               // an ack on the last allowed cycle still wins over the timeout
               if (i_mem_ack) begin
                  r_word <= i_mem_rdata;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == LP_CNT_LAST)
                     r_berr <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = r_word[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load = 32'h0;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = r_word;
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = 32'h0;
      endcase
   end

   always_comb begin
      w_merged = r_word;
      case (r_funct3[1:0])
         2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
         2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_RESP);
   assign o_misaligned = (r_state == S_RESP) && r_mis;
   assign o_bus_err    = (r_state == S_RESP) && r_berr;
   assign o_rdata      = ((r_state == S_RESP) && !r_we && !r_mis && !r_berr) ? w_load : 32'h0;
   assign o_mem_stb    = (r_state == S_READ);
   assign o_mem_wr_en  = (r_state == S_WRITE);
   assign o_mem_addr   = ((r_state == S_READ) || (r_state == S_WRITE)) ? {r_addr[31:2], 2'b00} : 32'h0;
   assign o_mem_wdata  = (r_state == S_WRITE) ? w_merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses against a byte-level
// memory model with a programmable ack delay.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic        i_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_rdata;
   logic        o_misaligned;
   logic        o_bus_err;
   logic        o_mem_stb;
   logic        o_mem_wr_en;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] mem [0:15];

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
      .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
      .o_mem_stb(o_mem_stb), .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] f3, input int lane);
      int nb = 1 << f3[1:0];
      logic [31:0] v = w >> (8 * lane);
      if (nb == 1) v = (!f3[2] && v[7])  ? ((v & 32'hFF)   | 32'hFFFFFF00) : (v & 32'hFF);
      if (nb == 2) v = (!f3[2] && v[15]) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
      return v;
   endfunction

   function automatic logic [31:0] f_store(input logic [31:0] w, input logic [31:0] wd,
                                           input logic [2:0] f3, input int lane);
      logic [31:0] r = w;
      for (int i = 0; i < (1 << f3[1:0]); i++) r[8 * (lane + i) +: 8] = wd[8 * i +: 8];
      return r;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
      chk({tag, "_ctl"}, {27'h0, o_done, o_misaligned, o_bus_err, o_mem_stb, o_mem_wr_en}, 32'h0);
      chk({tag, "_data"}, o_rdata | o_mem_addr | o_mem_wdata, 32'h0);
   endtask

   // dly = stb cycles without ack before the acking one; dly >= 16 never acks.
   task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int dly);
      int nb = 1 << f3[1:0];
      int lane = int'(a[1:0]);
      bit ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
      bit mis = !ill && ((lane % nb) != 0);
      logic [31:0] word = mem[a[5:2]];
      int exp_lat, exp_stb, exp_wr, k, n_stb, n_wr, lat;
      bit exp_berr, done, excl_bad, addr_bad, got_mis, got_berr;
      logic [31:0] exp_rd, exp_word, wr_a, wr_d, got_rd;
      exp_rd = 32'h0; exp_word = word; exp_berr = ill; exp_wr = 0; exp_stb = 0;
      if (ill || mis) exp_lat = 1;
      else if (we && nb == 4) begin exp_lat = 2; exp_wr = 1; exp_word = wd; end
      else if (dly >= 16) begin exp_lat = 17; exp_stb = 16; exp_berr = 1; end
      else begin
         exp_stb = dly + 1;
         if (!we) begin exp_lat = dly + 2; exp_rd = f_load(word, f3, lane); end
         else begin exp_lat = dly + 3; exp_wr = 1; exp_word = f_store(word, wd, f3, lane); end
      end

      @(negedge clk);
      i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
      @(posedge clk);
      #1;
      i_req = 1'b0; i_we = 1'($urandom); i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
      done = 0; k = 0; n_stb = 0; n_wr = 0; lat = 0; excl_bad = 0; addr_bad = 0;
      wr_a = 32'h0; wr_d = 32'h0; got_rd = 32'h0; got_mis = 0; got_berr = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         i_req = 1'($urandom);
         if (o_mem_stb && o_mem_wr_en) excl_bad = 1;
         if (o_mem_stb) begin
            n_stb++;
            if (o_mem_addr !== {a[31:2], 2'b00}) addr_bad = 1;
            i_mem_ack = (n_stb > dly);
            i_mem_rdata = i_mem_ack ? mem[a[5:2]] : $urandom;
         end else begin
            i_mem_ack = 1'b0;
            i_mem_rdata = $urandom;
         end
         if (o_mem_wr_en) begin
            n_wr++; wr_a = o_mem_addr; wr_d = o_mem_wdata;
            mem[o_mem_addr[5:2]] = o_mem_wdata;
         end
         if (o_done) begin
            done = 1; lat = k; got_rd = o_rdata; got_mis = o_misaligned; got_berr = o_bus_err;
            i_req = 1'b0;
         end
      end
      i_mem_ack = 1'b0;
      i_req = 1'b0;
      chk("done_latency", 32'(lat), 32'(exp_lat));
      chk("rdata", got_rd, exp_rd);
      chk("flags", {30'h0, got_mis, got_berr}, {30'h0, mis, exp_berr});
      chk("stb_cycles", 32'(n_stb), 32'(exp_stb));
      chk("wr_cycles", 32'(n_wr), 32'(exp_wr));
      chk("stb_wr_excl_addr", {30'h0, excl_bad, addr_bad}, 32'h0);
      if (exp_wr == 1) begin
         chk("wr_addr", wr_a, {a[31:2], 2'b00});
         chk("wr_data", wr_d, exp_word);
      end
      @(negedge clk);
      check_idle_outputs("post_done");
   endtask

   initial begin
      int nd, nw;
      rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'h0; i_addr = 32'h0; i_wdata = 32'h0;
      i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      mem[4] = 32'h8899AABB;
      access(0, 3'b010, 32'h10, 32'h0, 0);
      mem[4] = 32'h80112233;
      access(0, 3'b000, 32'h13, 32'h0, 0);
      chk("lb_const", f_load(32'h80112233, 3'b000, 3), 32'hFFFFFF80);
      access(0, 3'b100, 32'h13, 32'h0, 1);
      access(0, 3'b001, 32'h12, 32'h0, 2);
      mem[8] = 32'h11223344;
      access(1, 3'b000, 32'h21, 32'h000000EE, 0);
      chk("sb_mem_word", mem[8], 32'h1122EE44);
      access(1, 3'b001, 32'h22, 32'h0000BEEF, 3);
      access(1, 3'b010, 32'h2C, 32'hCAFEF00D, 0);
      access(0, 3'b010, 32'h06, 32'h0, 0);
      access(0, 3'b011, 32'h08, 32'h0, 0);
      access(1, 3'b100, 32'h08, 32'h0, 0);
      access(0, 3'b010, 32'h30, 32'h0, 20);
      access(1, 3'b000, 32'h31, 32'h55, 20);
      access(0, 3'b001, 32'h35, 32'h0, 0);

      // reset in READ aborts a store with no write and no done
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h40; i_wdata = 32'h1234;
      @(posedge clk);
      #1 i_req = 1'b0;
      @(negedge clk);
      chk("rst_in_read_stb", {31'h0, o_mem_stb}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_rst");
      nd = 0; nw = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (o_done) nd++;
         if (o_mem_wr_en) nw++;
      end
      chk("rst_abort_done_wr", 32'(nd + nw), 32'h0);
      access(0, 3'b010, 32'h44, 32'h0, 0);

      for (int t = 0; t < 60; t++) begin
         logic [31:0] a = $urandom;
         int d = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         access(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
